// File: rtl/uart_tx_ctrl_if.sv
// CPU-side bus bundle for the memory-mapped UART transmitter.
// Carries the store strobe, store data and the line/status outputs.
interface uart_tx_ctrl_if;
  logic        sel;
  logic        we;
  logic [31:0] wdata;
  logic        tx;
  logic [7:0]  status;
  logic        tx_done;

  modport master (
    output sel,
    output we,
    output wdata,
    input  tx,
    input  status,
    input  tx_done
  );

  modport slave (
    input  sel,
    input  we,
    input  wdata,
    output tx,
    output status,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter with a one-byte holding register,
// sticky overrun flag and a pollable status byte.
//
// state | meaning
// IDLE  | line high, waiting for the holding register to fill
// START | start bit (line low) for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | stop bit (line high); reloads directly when a byte is pending
module uart_tx_ctrl #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_ctrl_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW           = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          overrun_q, overrun_d;
  logic          tx_q, tx_d;
  logic          tx_done_q, tx_done_d;
  logic [7:0]    status_q, status_d;

  logic          wr;
  logic          clr_wr;
  logic          data_wr;
  logic          bit_end;
  logic          drain;
  logic          accept;

  logic          unused_wdata;
  assign unused_wdata = ^bus.wdata[30:8];

  // Write decode. A data write is still accepted when the pending byte
  // moves into the shift register on the same edge.
  always_comb begin
    wr      = bus.sel && bus.we;
    clr_wr  = wr && bus.wdata[31];
    data_wr = wr && !bus.wdata[31];
    bit_end = (baud_q == BAUD_LAST);
    drain   = hold_full_q &&
              ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    accept  = data_wr && (!hold_full_q || drain);
  end

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (hold_full_q) begin
          state_d = START;
          shift_d = hold_q;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          if (hold_full_q) begin
            state_d = START;
            shift_d = hold_q;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    hold_d      = accept ? bus.wdata[7:0] : hold_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_full_d = 1'b1;
    end else if (drain) begin
      hold_full_d = 1'b0;
    end

    overrun_d = overrun_q;
    if (clr_wr) begin
      overrun_d = 1'b0;
    end else if (data_wr && !accept) begin
      overrun_d = 1'b1;
    end

    // Registered so the pulse lines up with the last cycle of the stop bit.
    tx_done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
    status_d  = {5'b0, overrun_d, hold_full_d, state_d != IDLE};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      tx_q        <= 1'b1;
      tx_done_q   <= 1'b0;
      status_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
      tx_q        <= tx_d;
      tx_done_q   <= tx_done_d;
      status_q    <= status_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_done = tx_done_q;
  assign bus.status  = status_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl at 10 clocks per bit; a line receiver
// decodes frames from tx and the stimulus checks bytes, timing and status.
module tb_uart_tx_ctrl;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = 10;
  localparam int FRAME    = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_ctrl_if bus_if ();

  uart_tx_ctrl #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [7:0] rx_q[$];
  logic       rx_stop_q[$];
  int         start_q[$];
  logic [7:0] rx_b;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus_if.tx_done === 1'b1) done_cnt <= done_cnt + 1;

  // Line receiver: start detected at a falling clock edge inside bit cycle 1,
  // every bit then sampled at its middle.
  initial begin : line_rx
    forever begin
      @(negedge clk);
      if (bus_if.tx === 1'b0) begin
        start_q.push_back(cyc);
        repeat (CPB / 2 - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_b[i] = bus_if.tx;
        end
        repeat (CPB) @(negedge clk);
        rx_stop_q.push_back(bus_if.tx);
        rx_q.push_back(rx_b);
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] d, input logic s = 1'b1);
    @(negedge clk);
    bus_if.sel   = s;
    bus_if.we    = 1'b1;
    bus_if.wdata = d;
    @(posedge clk);
    #1;
    bus_if.sel   = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.wdata = 32'h0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, (done_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp);
    if (rx_q.size() == 0) begin
      check({tag, "_missing"}, 0, 1);
    end else begin
      check(tag, {24'h0, rx_q.pop_front()}, {24'h0, exp});
      check({tag, "_stop"}, {31'h0, rx_stop_q.pop_front()}, 1);
    end
  endtask

  task automatic check_gap(input string tag, input int idx);
    if (start_q.size() <= idx) begin
      check({tag, "_missing"}, 0, 1);
    end else begin
      check(tag, start_q[idx] - start_q[idx-1], FRAME);
    end
  endtask

  task automatic flush();
    rx_q.delete();
    rx_stop_q.delete();
    start_q.delete();
  endtask

  initial begin : stim
    int d0;
    int wave_err;
    int done_err;
    int idle_err;
    logic [9:0] frame_bits;
    logic [31:0] ign_data[3];

    bus_if.sel   = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.wdata = 32'h0;
    rst = 1'b1;
    tick(3);
    check("rst_tx", {31'h0, bus_if.tx}, 1);
    check("rst_status", {24'h0, bus_if.status}, 32'h00);
    check("rst_done", {31'h0, bus_if.tx_done}, 0);
    rst = 1'b0;
    tick(2);

    // 1: single frame 0x55, exact waveform and tx_done position
    flush();
    d0 = done_cnt;
    bus_write(32'h55);
    check("t1_status_e", {24'h0, bus_if.status}, 32'h02);
    check("t1_tx_e", {31'h0, bus_if.tx}, 1);
    tick();
    check("t1_tx_e1", {31'h0, bus_if.tx}, 0);
    check("t1_status_e1", {24'h0, bus_if.status}, 32'h01);
    frame_bits = 10'b1_0101_0101_0;
    wave_err = 0;
    done_err = 0;
    for (int k = 1; k <= FRAME; k++) begin
      if (bus_if.tx !== frame_bits[(k-1)/CPB]) wave_err++;
      if (bus_if.tx_done !== (k == FRAME)) done_err++;
      tick();
    end
    check("t1_wave_err", wave_err, 0);
    check("t1_done_err", done_err, 0);
    check("t1_status_end", {24'h0, bus_if.status}, 32'h00);
    check("t1_done_cnt", done_cnt - d0, 1);
    check_rx("t1_byte", 8'h55);
    tick(5);

    // 2: second write mid-frame, back-to-back frames
    flush();
    d0 = done_cnt;
    bus_write(32'hA3);
    tick(29);
    bus_write(32'h0F);
    check("t2_status_2nd", {24'h0, bus_if.status}, 32'h03);
    wait_done("t2", d0 + 2, 3 * FRAME);
    check("t2_status_end", {24'h0, bus_if.status}, 32'h00);
    check("t2_done_cnt", done_cnt - d0, 2);
    check_rx("t2_byte0", 8'hA3);
    check_rx("t2_byte1", 8'h0F);
    check_gap("t2_gap", 1);
    tick(5);

    // 3: overrun on third write, then clear
    flush();
    d0 = done_cnt;
    bus_write(32'h11);
    tick(20);
    bus_write(32'h22);
    check("t3_status_2nd", {24'h0, bus_if.status}, 32'h03);
    tick(5);
    bus_write(32'h33);
    check("t3_status_ovr", {24'h0, bus_if.status}, 32'h07);
    bus_write(32'h8000_0000);
    check("t3_status_clr", {24'h0, bus_if.status}, 32'h03);
    wait_done("t3", d0 + 2, 3 * FRAME);
    check("t3_status_end", {24'h0, bus_if.status}, 32'h00);
    check_rx("t3_byte0", 8'h11);
    check_rx("t3_byte1", 8'h22);
    tick(20);
    check("t3_no_extra", rx_q.size(), 0);

    // 4: write exactly on the STOP reload edge
    flush();
    d0 = done_cnt;
    bus_write(32'h5A);
    tick();
    bus_write(32'hC3);
    check("t4_status_2nd", {24'h0, bus_if.status}, 32'h03);
    tick(FRAME - 2);
    bus_write(32'h3C);
    check("t4_status_reload", {24'h0, bus_if.status}, 32'h03);
    check("t4_tx_reload", {31'h0, bus_if.tx}, 0);
    wait_done("t4", d0 + 3, 4 * FRAME);
    check("t4_status_end", {24'h0, bus_if.status}, 32'h00);
    check_rx("t4_byte0", 8'h5A);
    check_rx("t4_byte1", 8'hC3);
    check_rx("t4_byte2", 8'h3C);
    check_gap("t4_gap1", 1);
    check_gap("t4_gap2", 2);
    tick(5);

    // 5: reset mid-frame discards the frame and the pending byte
    flush();
    d0 = done_cnt;
    bus_write(32'h96);
    tick();
    bus_write(32'h69);
    tick(43);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_tx_rst", {31'h0, bus_if.tx}, 1);
    check("t5_status_rst", {24'h0, bus_if.status}, 32'h00);
    idle_err = 0;
    for (int k = 0; k < 120; k++) begin
      if (bus_if.tx !== 1'b1 || bus_if.status !== 8'h00) idle_err++;
      tick();
    end
    check("t5_idle_err", idle_err, 0);
    check("t5_no_done", done_cnt - d0, 0);
    flush();
    bus_write(32'hFF);
    wait_done("t5", d0 + 1, 2 * FRAME);
    check("t5_status_end", {24'h0, bus_if.status}, 32'h00);
    check_rx("t5_byte", 8'hFF);
    tick(5);

    // 6: writes without select are ignored
    flush();
    d0 = done_cnt;
    ign_data[0] = 32'h0000_0012;
    ign_data[1] = 32'h8000_0000;
    ign_data[2] = 32'h0000_00FF;
    for (int i = 0; i < 3; i++) bus_write(ign_data[i], 1'b0);
    idle_err = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus_if.tx !== 1'b1 || bus_if.status !== 8'h00) idle_err++;
      tick();
    end
    check("t6_idle_err", idle_err, 0);
    check("t6_no_frames", start_q.size(), 0);
    check("t6_no_done", done_cnt - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
